game_input_ctrl: RTL and testbench
==================================

# game_input_ctrl

Front-end controller for the two-player light-cycle game. It synchronizes and debounces the raw player buttons and runs the game-phase state machine. It produces the per-frame `p1_info`/`p2_info` one-hot direction codes and the `dflt` position-reset flag consumed by `draw_object`. All outputs change only at the frame tick, the same tick on which `draw_object` commits positions.

## Interface
Parameters:
- `DB_CYCLES`, default 200000: consecutive stable cycles before a debounced button changes state; legal range ≥ 2.
- `LAST_ROW`, default 10'd599: row value of the frame tick.
- `LAST_COL`, default 10'd799: column value of the frame tick.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system/pixel clock.
- `reset`  in  1  synchronous, active-high.
- `row`  in  10  current scan row.
- `col`  in  10  current scan column.
- `p1_btn`  in  4  raw player-1 buttons, asynchronous; bit0 up, bit1 down, bit2 left, bit3 right.
- `p2_btn`  in  4  raw player-2 buttons, same bit order as `p1_btn`.
- `start_btn`  in  1  raw start button, asynchronous.
- `p1_crash`  in  1  player 1 collided this frame; valid at the frame tick.
- `p2_crash`  in  1  player 2 collided this frame; valid at the frame tick.
- `p1_info`  out  4  player-1 direction, one-hot: 0001 up, 0010 down, 0100 left, 1000 right; 0000 means stopped.
- `p2_info`  out  4  player-2 direction, same encoding as `p1_info`.
- `dflt`  out  1  hold players at their start positions.
- `game_over`  out  1  high while the state is OVER.
- `winner`  out  2  01 means P1 won, 10 means P2 won, 11 means draw, 00 means none.

## Operation
- `tick` = (row == LAST_ROW) && (col == LAST_COL). It is one cycle wide per frame.
- Each of the 9 button inputs passes through a 2-flop synchronizer, then a debouncer.
  - The debounced state flips only after the synchronized input has differed from it for DB_CYCLES consecutive cycles.
  - Any cycle of agreement clears the counter.
  - The counter saturates and does not wrap.
- `start_req` is a sticky flag.
  - Set on a debounced rising edge of start.
  - Cleared at the tick that consumes it.
  - Cleared by reset.
- The state machine has three states and transitions only at a tick:
  - IDLE: `dflt`=1, both info=0000. With `start_req` set, go to PLAY and load p1 dir=0001 (up) and p2 dir=0010 (down).
  - PLAY: `dflt`=0, info = latched dirs.
    - Crash check: any crash at the tick → OVER.
    - `winner` = {p1_crash, p2_crash} mapped as: p2 only → 01; p1 only → 10; both → 11.
    - If there is no crash, the per-player direction update applies (next bullet).
  - OVER: `dflt`=0, info=0000 so the scene freezes, `game_over`=1. With `start_req` set, go to IDLE and clear `winner` to 00.
- Direction update per player at a PLAY tick:
  - Accept when exactly one debounced direction bit is pressed and it is not the opposite of the current direction (up/down, left/right).
  - Pressing the same direction as the current one is a no-op.
  - If zero buttons or two or more buttons are pressed, the direction is unchanged.
  - A reversal request is ignored; the direction is unchanged.
- Crash takes priority over a direction update at the same tick: the dirs freeze and the state goes to OVER.
- If `start_req` is set during PLAY, it is not consumed. It stays pending and triggers OVER → IDLE at the first tick in OVER.

## Timing
- Reset values: `p1_info`=0000, `p2_info`=0000, `dflt`=1, `game_over`=0, `winner`=00, state=IDLE, debouncers=released, synchronizers=0, `start_req`=0.
- Reset mid-game returns to IDLE on the next cycle, regardless of tick.
- Outputs are registered and change only in the cycle after a tick (or after reset).
  - `draw_object` samples at that same tick, so a new direction moves the sprite one frame later.
- Button-to-output latency is 2 sync cycles + DB_CYCLES, then the wait to the next tick, then +1 cycle.
- `p1_crash`/`p2_crash` are ignored outside PLAY.

## Structure
- Package `tron_pkg` contains:
  - Direction constants: DIR_UP=4'b0001, DIR_DOWN=4'b0010, DIR_LEFT=4'b0100, DIR_RIGHT=4'b1000, DIR_STOP=4'b0000.
  - Enum `game_state_t` {IDLE, PLAY, OVER}.
  - `winner` codes.
  - A helper function `opposite(dir)`.
- Sub-module `button_debounce` #(DB_CYCLES) contains the synchronizer and the counter for a single bit. It is instantiated 9 times.

## Test plan
All scenarios use DB_CYCLES=4, and the bench drives `row`/`col` to 599/799 to create ticks.
- Reset, then 3 ticks with no buttons → `dflt`=1, info=0000/0000, `winner`=00, `game_over`=0 throughout.
- Start held 6 cycles, then a tick → next cycle `dflt`=0, `p1_info`=0001, `p2_info`=0010.
- In PLAY, p1 presses right (1000) for 6 cycles, then a tick → `p1_info`=1000. With p1 dir=0001, p1 pressing down (0010) → `p1_info` stays 0001.
- Bounce test: p2 left pulses 3 cycles on, 1 off, repeated 3 times → no change at the tick. A 2-cycle glitch on start → IDLE persists.
- Collision: `p2_crash`=1 at a tick → `game_over`=1, `winner`=01, info=0000. Both crashes → `winner`=11. Start, then a tick → IDLE, `winner`=00, `dflt`=1.
- p1 presses up+left together → no change. Reset asserted during PLAY → next cycle all outputs equal their reset values.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared constants, state encoding and direction helpers for the light-cycle input front end.
package tron_pkg;

   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_DOWN  = 4'b0010;
   localparam logic [3:0] DIR_LEFT  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;
   localparam logic [3:0] DIR_STOP  = 4'b0000;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } game_state_t;

   function automatic logic [3:0] opposite(input logic [3:0] dir);
      logic [3:0] res;
      case (dir)
         DIR_UP:    res = DIR_DOWN;
         DIR_DOWN:  res = DIR_UP;
         DIR_LEFT:  res = DIR_RIGHT;
         DIR_RIGHT: res = DIR_LEFT;
         default:   res = DIR_STOP;
      endcase
      return res;
   endfunction

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   // Single legal, non-reversing press replaces the heading; anything else keeps it.
   function automatic logic [3:0] next_dir(input logic [3:0] cur, input logic [3:0] req);
      logic [3:0] res;
      res = cur;
      if (is_onehot(req) && (req != opposite(cur))) begin
         res = req;
      end
      return res;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce counter for one raw button.
module button_debounce
   import tron_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 200000
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic btn_i,
   output logic db_o
);

   localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync0_q, sync1_q;
   logic             state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter runs only while the synchronized input disagrees; it flips the state on the last count.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (sync1_q != state_q) begin
         if (cnt_q == CNT_LAST) begin
            state_d = ~state_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         sync0_q <= 1'b0;
         sync1_q <= 1'b0;
         state_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync0_q <= btn_i;
         sync1_q <= sync0_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign db_o = state_q;

endmodule

// File: rtl/game_input_ctrl.sv
// Light-cycle front end: debounced player/start buttons and the frame-tick game-phase FSM.
module game_input_ctrl
   import tron_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 200000,
   parameter logic [9:0]  LAST_ROW  = 10'd599,
   parameter logic [9:0]  LAST_COL  = 10'd799
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] row,
   input  logic [9:0] col,
   input  logic [3:0] p1_btn,
   input  logic [3:0] p2_btn,
   input  logic       start_btn,
   input  logic       p1_crash,
   input  logic       p2_crash,
   output logic [3:0] p1_info,
   output logic [3:0] p2_info,
   output logic       dflt,
   output logic       game_over,
   output logic [1:0] winner
);

   logic [3:0]  p1_db, p2_db;
   logic        start_db;
   logic        tick_c, start_rise_c, consume_c;

   game_state_t state_q, state_d;
   logic [3:0]  p1_dir_q, p1_dir_d;
   logic [3:0]  p2_dir_q, p2_dir_d;
   logic [1:0]  winner_q, winner_d;
   logic        start_req_q, start_req_d;
   logic        start_prev_q;
   logic [3:0]  p1_info_q, p1_info_d;
   logic [3:0]  p2_info_q, p2_info_d;
   logic        dflt_q, dflt_d;
   logic        game_over_q, game_over_d;

   for (genvar i = 0; i < 4; i++) begin : g_dir_db
      button_debounce #(.DB_CYCLES(DB_CYCLES)) u_p1_db (
         .clock_i (clock),
         .reset_i (reset),
         .btn_i   (p1_btn[i]),
         .db_o    (p1_db[i])
      );
      button_debounce #(.DB_CYCLES(DB_CYCLES)) u_p2_db (
         .clock_i (clock),
         .reset_i (reset),
         .btn_i   (p2_btn[i]),
         .db_o    (p2_db[i])
      );
   end

   button_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (
      .clock_i (clock),
      .reset_i (reset),
      .btn_i   (start_btn),
      .db_o    (start_db)
   );

   assign tick_c       = (row == LAST_ROW) && (col == LAST_COL);
   assign start_rise_c = start_db & ~start_prev_q;

   // Next-state and registered-output logic; everything advances only on the frame tick.
   always_comb begin
      state_d     = state_q;
      p1_dir_d    = p1_dir_q;
      p2_dir_d    = p2_dir_q;
      winner_d    = winner_q;
      consume_c   = 1'b0;
      p1_info_d   = DIR_STOP;
      p2_info_d   = DIR_STOP;
      dflt_d      = 1'b0;
      game_over_d = 1'b0;

      if (tick_c) begin
         case (state_q)
            IDLE: begin
               if (start_req_q) begin
                  state_d   = PLAY;
                  p1_dir_d  = DIR_UP;
                  p2_dir_d  = DIR_DOWN;
                  consume_c = 1'b1;
               end
            end
            PLAY: begin
               // Crash wins over steering: headings freeze where they were.
               if (p1_crash || p2_crash) begin
                  state_d  = OVER;
                  winner_d = {p1_crash, p2_crash};
               end else begin
                  p1_dir_d = next_dir(p1_dir_q, p1_db);
                  p2_dir_d = next_dir(p2_dir_q, p2_db);
               end
            end
            OVER: begin
               if (start_req_q) begin
                  state_d   = IDLE;
                  winner_d  = WIN_NONE;
                  consume_c = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      start_req_d = (start_req_q & ~consume_c) | start_rise_c;

      if (state_d == PLAY) begin
         p1_info_d = p1_dir_d;
         p2_info_d = p2_dir_d;
      end
      dflt_d      = (state_d == IDLE);
      game_over_d = (state_d == OVER);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         p1_dir_q     <= DIR_STOP;
         p2_dir_q     <= DIR_STOP;
         winner_q     <= WIN_NONE;
         start_req_q  <= 1'b0;
         start_prev_q <= 1'b0;
         p1_info_q    <= DIR_STOP;
         p2_info_q    <= DIR_STOP;
         dflt_q       <= 1'b1;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         p1_dir_q     <= p1_dir_d;
         p2_dir_q     <= p2_dir_d;
         winner_q     <= winner_d;
         start_req_q  <= start_req_d;
         start_prev_q <= start_db;
         p1_info_q    <= p1_info_d;
         p2_info_q    <= p2_info_d;
         dflt_q       <= dflt_d;
         game_over_q  <= game_over_d;
      end
   end

   assign p1_info   = p1_info_q;
   assign p2_info   = p2_info_q;
   assign dflt      = dflt_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed bench for game_input_ctrl with a short debounce window and hand-driven frame ticks.
module tb_game_input_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [9:0] row = 10'd0;
   logic [9:0] col = 10'd0;
   logic [3:0] p1_btn = 4'd0;
   logic [3:0] p2_btn = 4'd0;
   logic       start_btn = 1'b0;
   logic       p1_crash = 1'b0;
   logic       p2_crash = 1'b0;
   logic [3:0] p1_info, p2_info;
   logic       dflt, game_over;
   logic [1:0] winner;

   int vectors = 0;
   int errors  = 0;

   game_input_ctrl #(
      .DB_CYCLES (4),
      .LAST_ROW  (10'd599),
      .LAST_COL  (10'd799)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .p1_btn    (p1_btn),
      .p2_btn    (p2_btn),
      .start_btn (start_btn),
      .p1_crash  (p1_crash),
      .p2_crash  (p2_crash),
      .p1_info   (p1_info),
      .p2_info   (p2_info),
      .dflt      (dflt),
      .game_over (game_over),
      .winner    (winner)
   );

   always #5 clock = ~clock;

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] e_p1, input logic [3:0] e_p2,
                          input logic e_dflt, input logic e_go, input logic [1:0] e_win);
      chk({tag, ".p1_info"}, p1_info, e_p1);
      chk({tag, ".p2_info"}, p2_info, e_p2);
      chk({tag, ".dflt"}, {3'b0, dflt}, {3'b0, e_dflt});
      chk({tag, ".game_over"}, {3'b0, game_over}, {3'b0, e_go});
      chk({tag, ".winner"}, {2'b0, winner}, {2'b0, e_win});
   endtask

   task automatic tick(input logic c1, input logic c2);
      row = 10'd599; col = 10'd799; p1_crash = c1; p2_crash = c2;
      step(1);
      row = 10'd0; col = 10'd0; p1_crash = 1'b0; p2_crash = 1'b0;
   endtask

   task automatic press_start();
      start_btn = 1'b1;
      step(6);
      start_btn = 1'b0;
      step(8);
   endtask

   // Holds buttons long enough to debounce, releases, then issues a tick while still debounced.
   task automatic press_dirs(input logic [3:0] b1, input logic [3:0] b2);
      p1_btn = b1; p2_btn = b2;
      step(6);
      p1_btn = 4'd0; p2_btn = 4'd0;
      step(1);
      tick(1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      chk_all("reset", 4'b0000, 4'b0000, 1'b1, 1'b0, 2'b00);

      for (int i = 0; i < 3; i++) begin
         step(2);
         tick(1'b0, 1'b0);
         chk_all("idle_tick", 4'b0000, 4'b0000, 1'b1, 1'b0, 2'b00);
      end

      start_btn = 1'b1;
      step(2);
      start_btn = 1'b0;
      step(10);
      tick(1'b0, 1'b0);
      chk_all("start_glitch", 4'b0000, 4'b0000, 1'b1, 1'b0, 2'b00);

      tick(1'b1, 1'b1);
      chk_all("crash_in_idle", 4'b0000, 4'b0000, 1'b1, 1'b0, 2'b00);

      press_start();
      chk("pending_no_tick.dflt", {3'b0, dflt}, 4'b0001);
      tick(1'b0, 1'b0);
      chk_all("start_play", 4'b0001, 4'b0010, 1'b0, 1'b0, 2'b00);

      press_dirs(4'b0010, 4'b0000);
      chk("p1_reverse_down", p1_info, 4'b0001);
      step(8);

      p1_btn = 4'b1000;
      step(6);
      chk("p1_right_before_tick", p1_info, 4'b0001);
      p1_btn = 4'b0000;
      step(1);
      tick(1'b0, 1'b0);
      chk("p1_right", p1_info, 4'b1000);
      chk("p2_hold", p2_info, 4'b0010);
      step(8);

      press_dirs(4'b0100, 4'b0000);
      chk("p1_reverse_left", p1_info, 4'b1000);
      step(8);

      for (int i = 0; i < 3; i++) begin
         p2_btn = 4'b0100;
         step(3);
         p2_btn = 4'b0000;
         step(1);
      end
      step(1);
      tick(1'b0, 1'b0);
      chk("p2_bounce", p2_info, 4'b0010);
      step(8);

      press_dirs(4'b0000, 4'b0100);
      chk("p2_left", p2_info, 4'b0100);
      step(8);

      press_dirs(4'b0101, 4'b0000);
      chk("p1_two_buttons", p1_info, 4'b1000);
      step(8);

      press_start();
      tick(1'b0, 1'b0);
      chk_all("start_in_play", 4'b1000, 4'b0100, 1'b0, 1'b0, 2'b00);

      tick(1'b0, 1'b1);
      chk_all("p2_crash", 4'b0000, 4'b0000, 1'b0, 1'b1, 2'b01);

      tick(1'b0, 1'b0);
      chk_all("pending_start_idle", 4'b0000, 4'b0000, 1'b1, 1'b0, 2'b00);

      press_start();
      tick(1'b0, 1'b0);
      chk_all("restart_play", 4'b0001, 4'b0010, 1'b0, 1'b0, 2'b00);

      tick(1'b1, 1'b1);
      chk_all("both_crash", 4'b0000, 4'b0000, 1'b0, 1'b1, 2'b11);

      tick(1'b1, 1'b0);
      chk("over_ignores_crash.winner", {2'b0, winner}, 4'b0011);

      press_start();
      tick(1'b0, 1'b0);
      chk_all("over_to_idle", 4'b0000, 4'b0000, 1'b1, 1'b0, 2'b00);

      press_start();
      tick(1'b0, 1'b0);
      chk("third_game.p1_info", p1_info, 4'b0001);
      reset = 1'b1;
      step(1);
      chk_all("reset_in_play", 4'b0000, 4'b0000, 1'b1, 1'b0, 2'b00);
      reset = 1'b0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
